// File: rtl/fpu_pipe_ctl.sv
// rtl/fpu_pipe_ctl.sv - FP pipeline control: E1/E2/E3/WB stages, div/sqrt hold, 2-write-port regfile
module fpu_pipe_ctl #(
  parameter int DIV_CYC  = 4,
  parameter int SQRT_CYC = 6
) (
  input  logic        clk,
  input  logic        clrn,
  // ID stage
  input  logic [4:0]  fs,
  input  logic [4:0]  ft,
  input  logic [4:0]  fd,
  input  logic [2:0]  fc,
  input  logic        wf,
  input  logic        fasmds,
  // result of the op currently in E3
  input  logic [31:0] e3r,
  // lwc1 writeback from the integer unit
  input  logic        wwfpr,
  input  logic [4:0]  wrn,
  input  logic [31:0] wmo,
  // stage visibility
  output logic [4:0]  e1n,
  output logic [4:0]  e2n,
  output logic [4:0]  e3n,
  output logic        e1w,
  output logic        e2w,
  output logic        e3w,
  output logic [2:0]  e1c,
  // register read data
  output logic [31:0] dfa,
  output logic [31:0] dfb,
  output logic [31:0] e3d,
  // hazards
  output logic        stall,
  output logic        st
);

  localparam logic [2:0] FC_DIV  = 3'b100;
  localparam logic [2:0] FC_SQRT = 3'b101;

  localparam int CNT_MAX = (DIV_CYC > SQRT_CYC) ? DIV_CYC : SQRT_CYC;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC);
  localparam logic [CW-1:0] SQRT_LOAD = CW'(SQRT_CYC);

  // Stage registers. The opcode is only consumed by the datapath while the op
  // sits in E1, so later stages carry just destination and write-enable.
  logic [4:0]    e1_n, e2_n, e3_n, wb_n;
  logic          e1_w, e2_w, e3_w, wb_w;
  logic [2:0]    e1_c;
  logic [31:0]   wb_d;
  logic [CW-1:0] cnt;

  logic [31:0]   rf [32];

  logic          issue;
  logic          issue_div;
  logic          issue_sqrt;

  // Issue decode: an arithmetic op leaves ID only when the FPU is not busy
  always_comb begin
    issue      = fasmds & ~stall;
    issue_div  = issue & (fc == FC_DIV);
    issue_sqrt = issue & (fc == FC_SQRT);
  end

  // Busy flag and ID-hold indication
  always_comb begin
    stall = (cnt != '0);
    st    = stall & fasmds;
  end

  // E1: load a new op or a bubble; hold while a multi-cycle op is iterating
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1_n <= '0;
      e1_w <= 1'b0;
      e1_c <= '0;
    end else if (!stall) begin
      if (issue) begin
        e1_n <= fd;
        e1_w <= wf & fasmds;
        e1_c <= fc;
      end else begin
        e1_n <= '0;
        e1_w <= 1'b0;
        e1_c <= '0;
      end
    end
  end

  // E2: take E1 when it advances, otherwise receive a bubble during the hold
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e2_n <= '0;
      e2_w <= 1'b0;
    end else if (stall) begin
      e2_n <= '0;
      e2_w <= 1'b0;
    end else begin
      e2_n <= e1_n;
      e2_w <= e1_w;
    end
  end

  // E3 and WB always advance; WB captures the datapath result alongside
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e3_n <= '0;
      e3_w <= 1'b0;
      wb_n <= '0;
      wb_w <= 1'b0;
      wb_d <= '0;
    end else begin
      e3_n <= e2_n;
      e3_w <= e2_w;
      wb_n <= e3_n;
      wb_w <= e3_w;
      wb_d <= e3r;
    end
  end

  // Hold counter: loaded on div/sqrt issue, counts the extra E1 cycles down
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt - 1'b1;
    end else if (issue_div) begin
      cnt <= DIV_LOAD;
    end else if (issue_sqrt) begin
      cnt <= SQRT_LOAD;
    end
  end

  // Register file writes; the FPU port is applied last so it wins a collision
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wwfpr) begin
        rf[wrn] <= wmo;
      end
      if (wb_w) begin
        rf[wb_n] <= wb_d;
      end
    end
  end

  // Register file reads with same-cycle write bypass, FPU port first
  always_comb begin
    dfa = rf[fs];
    dfb = rf[ft];
    if (wb_w && (wb_n == fs)) begin
      dfa = wb_d;
    end else if (wwfpr && (wrn == fs)) begin
      dfa = wmo;
    end
    if (wb_w && (wb_n == ft)) begin
      dfb = wb_d;
    end else if (wwfpr && (wrn == ft)) begin
      dfb = wmo;
    end
  end

  // Stage state is exported directly
  always_comb begin
    e1n = e1_n;
    e2n = e2_n;
    e3n = e3_n;
    e1w = e1_w;
    e2w = e2_w;
    e3w = e3_w;
    e1c = e1_c;
    e3d = e3r;
  end

endmodule

// File: tb/tb_fpu_pipe_ctl.sv
// tb/tb_fpu_pipe_ctl.sv - directed self-checking bench for fpu_pipe_ctl
module tb_fpu_pipe_ctl;

  logic        clk;
  logic        clrn;
  logic [4:0]  fs, ft, fd;
  logic [2:0]  fc;
  logic        wf, fasmds;
  logic [31:0] e3r;
  logic        wwfpr;
  logic [4:0]  wrn;
  logic [31:0] wmo;
  logic [4:0]  e1n, e2n, e3n;
  logic        e1w, e2w, e3w;
  logic [2:0]  e1c;
  logic [31:0] dfa, dfb, e3d;
  logic        stall, st;

  int passed = 0;
  int total  = 0;

  fpu_pipe_ctl #(.DIV_CYC(4), .SQRT_CYC(6)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .fs     (fs),
    .ft     (ft),
    .fd     (fd),
    .fc     (fc),
    .wf     (wf),
    .fasmds (fasmds),
    .e3r    (e3r),
    .wwfpr  (wwfpr),
    .wrn    (wrn),
    .wmo    (wmo),
    .e1n    (e1n),
    .e2n    (e2n),
    .e3n    (e3n),
    .e1w    (e1w),
    .e2w    (e2w),
    .e3w    (e3w),
    .e1c    (e1c),
    .dfa    (dfa),
    .dfb    (dfb),
    .e3d    (e3d),
    .stall  (stall),
    .st     (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    clrn = 1'b0; fs = '0; ft = '0; fd = '0; fc = '0; wf = 1'b0; fasmds = 1'b0;
    e3r = '0; wwfpr = 1'b0; wrn = '0; wmo = '0;

    // reset state
    #1;
    chk("rst_e1n", 32'(e1n), 32'd0);
    chk("rst_e1w", 32'(e1w), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    tick();
    clrn = 1'b1;
    #1;
    chk("rst_e2n", 32'(e2n), 32'd0);
    chk("rst_e3n", 32'(e3n), 32'd0);
    chk("rst_e2w", 32'(e2w), 32'd0);
    chk("rst_e3w", 32'(e3w), 32'd0);
    chk("rst_e1c", 32'(e1c), 32'd0);
    chk("rst_st", 32'(st), 32'd0);
    chk("rst_dfa", dfa, 32'd0);
    chk("rst_dfb", dfb, 32'd0);

    // single add to f3
    fd = 5'd3; fc = 3'b000; wf = 1'b1; fasmds = 1'b1;
    tick();
    chk("add_e1n", 32'(e1n), 32'd3);
    chk("add_e1w", 32'(e1w), 32'd1);
    chk("add_e1c", 32'(e1c), 32'd0);
    fasmds = 1'b0;
    tick();
    chk("add_e2n", 32'(e2n), 32'd3);
    chk("add_e2w", 32'(e2w), 32'd1);
    chk("add_e1w_bubble", 32'(e1w), 32'd0);
    tick();
    chk("add_e3n", 32'(e3n), 32'd3);
    chk("add_e3w", 32'(e3w), 32'd1);
    e3r = 32'h3F80_0000;
    fs = 5'd3;
    #1;
    chk("add_e3d", e3d, 32'h3F80_0000);
    tick();
    chk("add_dfa_bypass", dfa, 32'h3F80_0000);
    e3r = '0;
    tick();
    chk("add_dfa_rf", dfa, 32'h3F80_0000);

    // back-to-back adds to f1, f2, f4
    fc = 3'b000; wf = 1'b1; fasmds = 1'b1;
    fd = 5'd1;
    tick();
    fd = 5'd2;
    tick();
    fd = 5'd4;
    tick();
    fasmds = 1'b0;
    chk("b2b_e1n", 32'(e1n), 32'd4);
    chk("b2b_e2n", 32'(e2n), 32'd2);
    chk("b2b_e3n", 32'(e3n), 32'd1);
    repeat (4) tick();

    // fdiv to f5 with a second op waiting in ID during the hold
    fd = 5'd5; fc = 3'b100; wf = 1'b1; fasmds = 1'b1;
    tick();
    chk("div_e1n", 32'(e1n), 32'd5);
    fd = 5'd6; fc = 3'b000;
    for (int i = 0; i < 4; i++) begin
      chk("div_stall", 32'(stall), 32'd1);
      chk("div_st", 32'(st), 32'd1);
      chk("div_e2w", 32'(e2w), 32'd0);
      chk("div_e1n_hold", 32'(e1n), 32'd5);
      if (i == 3) fasmds = 1'b0;
      tick();
    end
    chk("div_stall_end", 32'(stall), 32'd0);
    chk("div_st_end", 32'(st), 32'd0);
    chk("div_e1n_last", 32'(e1n), 32'd5);
    chk("div_e1c_last", 32'(e1c), 32'd4);
    tick();
    chk("div_e2n", 32'(e2n), 32'd5);
    chk("div_e2w", 32'(e2w), 32'd1);
    chk("div_no_issue", 32'(e1w), 32'd0);
    repeat (3) tick();

    // FPU and IU write f7 in the same cycle
    fd = 5'd7; fc = 3'b000; wf = 1'b1; fasmds = 1'b1;
    tick();
    fasmds = 1'b0;
    tick();
    tick();
    e3r = 32'h1111_1111;
    tick();
    e3r = '0;
    wwfpr = 1'b1; wrn = 5'd7; wmo = 32'h2222_2222; fs = 5'd7; ft = 5'd7;
    #1;
    chk("coll_dfa", dfa, 32'h1111_1111);
    chk("coll_dfb", dfb, 32'h1111_1111);
    tick();
    wwfpr = 1'b0;
    #1;
    chk("coll_rf7", dfa, 32'h1111_1111);

    // IU-only write with bypass, and f0 is writable
    wwfpr = 1'b1; wrn = 5'd9; wmo = 32'hDEAD_BEEF; fs = 5'd9;
    #1;
    chk("iu_bypass", dfa, 32'hDEAD_BEEF);
    tick();
    wwfpr = 1'b0;
    #1;
    chk("iu_rf9", dfa, 32'hDEAD_BEEF);
    wwfpr = 1'b1; wrn = 5'd0; wmo = 32'hA5A5_A5A5; ft = 5'd0;
    tick();
    wwfpr = 1'b0;
    #1;
    chk("f0_write", dfb, 32'hA5A5_A5A5);

    // fsqrt to f8 aborted by reset in the 3rd hold cycle
    fd = 5'd8; fc = 3'b101; wf = 1'b1; fasmds = 1'b1;
    tick();
    fasmds = 1'b0;
    chk("sqrt_hold1", 32'(stall), 32'd1);
    tick();
    chk("sqrt_hold2", 32'(stall), 32'd1);
    tick();
    chk("sqrt_hold3", 32'(stall), 32'd1);
    clrn = 1'b0;
    fs = 5'd3; ft = 5'd8;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_e1w", 32'(e1w), 32'd0);
    chk("abort_e2w", 32'(e2w), 32'd0);
    chk("abort_e3w", 32'(e3w), 32'd0);
    chk("abort_e1n", 32'(e1n), 32'd0);
    chk("abort_rf3", dfa, 32'd0);
    tick();
    clrn = 1'b1;
    repeat (10) tick();
    chk("abort_rf8", dfb, 32'd0);
    chk("abort_stall_after", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpu_pipe_ctl.md
FPU_PIPE_CTL -- requirements
Module: fpu_pipe_ctl

Interface
REQ-001 SHALL have parameter DIV_CYC, default 4: extra cycles an fdiv is held in E1.
REQ-002 SHALL have parameter SQRT_CYC, default 6: extra cycles an fsqrt is held in E1.
REQ-003 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have input clrn, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have inputs fs and ft, each 5 bits: FP source register numbers from ID.
REQ-006 SHALL have inputs fd (5 bits), fc (3 bits), wf (1 bit) and fasmds (1 bit): ID FP destination, opcode, write-enable and arithmetic-op-valid.
REQ-007 SHALL have input e3r, 32 bits: arithmetic result delivered by the external FP datapath for the op currently in E3.
REQ-008 SHALL have inputs wwfpr (1 bit), wrn (5 bits) and wmo (32 bits): lwc1 writeback from the integer unit.
REQ-009 SHALL have outputs e1n, e2n and e3n, each 5 bits, plus e1w, e2w and e3w, each 1 bit: destination number and write-enable of stages E1, E2 and E3.
REQ-010 SHALL have output e1c, 3 bits: opcode in E1, driven to the datapath.
REQ-011 SHALL have outputs dfa and dfb, each 32 bits: FP register read data for fs and ft.
REQ-012 SHALL have output e3d, 32 bits: equal to e3r, for forwarding.
REQ-013 SHALL have outputs stall and st, each 1 bit: FPU busy, and FP op held in ID.

Function
REQ-014 fc encoding SHALL be: 000 add, 001 sub, 010 mul, 100 div, 101 sqrt; other codes SHALL be treated as single-cycle in E1.
REQ-015 The pipeline SHALL have stages E1, E2, E3 and WB, each holding {n[4:0], w, c[2:0]}; WB SHALL also hold data wd[31:0].
REQ-016 Issue: when fasmds=1 and stall=0, E1 SHALL load {fd, wf & fasmds, fc} at the next edge; otherwise E1 SHALL load a bubble {0, 0, 000}.
REQ-017 When a div or sqrt is issued into E1, counter cnt SHALL load DIV_CYC or SQRT_CYC respectively at the same edge.
REQ-018 stall SHALL equal (cnt != 0), combinationally.
REQ-019 While stall=1: E1 SHALL hold its contents, E2 SHALL load a bubble every cycle, E3 and WB SHALL advance normally, and cnt SHALL decrement by 1.
REQ-020 On the edge where cnt goes from 1 to 0, E1 SHALL still hold; on the following edge E1 SHALL advance into E2 and may accept a new issue.
REQ-021 Latency for add/sub/mul: issue at edge N puts the op in E1 after N, E2 after N+1, E3 after N+2 and WB after N+3; the regfile write occurs at edge N+4.
REQ-022 A div with DIV_CYC=4 issued at edge N SHALL reach WB DIV_CYC cycles later than an add issued at edge N.
REQ-023 st SHALL equal stall & fasmds.
REQ-024 WB SHALL capture wd <= e3r together with the E3 control fields.
REQ-025 The regfile SHALL be 32x32 with two write ports: the FPU port (WB.w=1 writes rf[WB.n] <= wd) and the IU port (wwfpr=1 writes rf[wrn] <= wmo).
REQ-026 When both write ports address the same register in the same cycle, the FPU port SHALL win.
REQ-027 Reads SHALL be combinational with write bypass: if fs (or ft) matches an active write, dfa (or dfb) SHALL return the write data, with the FPU port taking priority over the IU port.
REQ-028 Register 0 SHALL be an ordinary writable FP register (no hardwired zero).
REQ-029 The e1*, e2* and e3* outputs SHALL reflect the stage registers directly; e1c SHALL equal E1.c.

Reset
REQ-030 clrn=0 SHALL asynchronously clear all stage registers, wd, cnt and all 32 regfile entries to 0.
REQ-031 While and immediately after reset, outputs SHALL be: e1n=e2n=e3n=0, e1w=e2w=e3w=0, e1c=0, stall=0, st=0, dfa=dfb=0.
REQ-032 clrn asserted while cnt != 0 SHALL abort the div/sqrt with no write to the regfile.

Verification
REQ-033 Add f3: fd=3, fc=000, wf=1, fasmds=1 for one cycle, e3r=0x3F800000 while the op is in E3 -> e3n=3 and e3w=1 two cycles after issue; rf[3]=0x3F800000 after edge N+4; dfa=0x3F800000 with fs=3.
REQ-034 fdiv with DIV_CYC=4, fd=5 -> stall=1 for exactly 4 cycles; a second fasmds during those cycles gives st=1 and is not issued; e2w=0 throughout the hold.
REQ-035 Same-cycle writes: WB writes f7=0x11111111 and wwfpr=1 with wrn=7, wmo=0x22222222 -> rf[7]=0x11111111; fs=7 reads 0x11111111 in that cycle.
REQ-036 Back-to-back adds to f1, f2, f4 on consecutive cycles -> e1n/e2n/e3n show 4/2/1 in the third cycle after the first issue.
REQ-037 Reset mid-fsqrt, with clrn low at the 3rd of 6 hold cycles -> stall=0 and all e*w=0 immediately; rf[fd] stays 0.
